// File: rtl/scan_cfg_pkg.sv
`default_nettype none
// ==========================================================================
// scan_cfg_pkg : shared state encoding and chain indices for scan loading
// Rev 1.0
// ==========================================================================
package scan_cfg_pkg;

    localparam int CNT_W_DEF  = 16;

    localparam int CHAIN_CLB  = 0;
    localparam int CHAIN_CONN = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_FIN     = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/scan_serializer.sv
`default_nettype none
// ==========================================================================
// scan_serializer : holds one configuration word and presents it LSB-first
// Rev 1.0
// ==========================================================================
module scan_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              bit_o,
    output logic              last_o
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q,  idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load_i) begin
            word_d = data_i;
            idx_d  = '0;
        end else if (advance_i) begin
            word_d = word_q >> 1;
            idx_d  = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign bit_o  = word_q[0];
    assign last_o = (idx_q == IDX_W'(DATA_W - 1));

endmodule
`default_nettype wire

// File: rtl/scan_cfg_loader.sv
`default_nettype none
// ==========================================================================
// scan_cfg_loader : streams configuration words into one fabric scan chain,
// optionally verifies old contents, then releases the fabric.  Rev 1.0
// ==========================================================================
module scan_cfg_loader
    import scan_cfg_pkg::*;
#(
    parameter int NUM_CHAINS = 2,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int RST_CYCLES = 2,
    // One spare code point so an out-of-range select can be expressed and rejected.
    localparam int SEL_W     = $clog2(NUM_CHAINS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SEL_W-1:0]      chain_sel,
    input  logic [CNT_W-1:0]      bit_count,
    input  logic                  verify,
    input  logic [DATA_W-1:0]     cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [NUM_CHAINS-1:0] scan_en,
    output logic [NUM_CHAINS-1:0] scan_in,
    input  logic [NUM_CHAINS-1:0] scan_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic                  fabric_clk_en,
    output logic                  fabric_reset
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [NUM_CHAINS-1:0] CHAIN0 = NUM_CHAINS'(1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] mism_q, mism_d;
    logic [RC_W-1:0]  rel_q, rel_d;
    logic             verify_q, verify_d;
    logic             err_q, err_d;
    logic             clk_en_q, clk_en_d;

    logic                  ser_load, ser_adv, ser_bit, ser_last;
    logic [NUM_CHAINS-1:0] sel_onehot;
    logic                  ret_bit;

    scan_serializer #(
        .DATA_W    (DATA_W)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load_i    (ser_load),
        .advance_i (ser_adv),
        .data_i    (cfg_data),
        .bit_o     (ser_bit),
        .last_o    (ser_last)
    );

    assign sel_onehot = (state_q == ST_SHIFT) ? (CHAIN0 << sel_q) : '0;
    assign ret_bit    = |(scan_out & sel_onehot);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rem_d    = rem_q;
        mism_d   = mism_q;
        rel_d    = rel_q;
        verify_d = verify_q;
        err_d    = err_q;
        clk_en_d = clk_en_q;
        ser_load = 1'b0;
        ser_adv  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d    = chain_sel;
                    rem_d    = bit_count;
                    verify_d = verify;
                    err_d    = 1'b0;
                    mism_d   = '0;
                    clk_en_d = 1'b0;
                    if ((bit_count == '0) || (chain_sel >= SEL_W'(NUM_CHAINS))) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (cfg_valid) begin
                    ser_load = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_adv = 1'b1;
                rem_d   = rem_q - CNT_W'(1);
                if (verify_q && (ser_bit != ret_bit) && (mism_q != '1)) begin
                    mism_d = mism_q + CNT_W'(1);
                end
                // The last bit may also be the last mismatch, so err looks at mism_d.
                if (rem_q == CNT_W'(1)) begin
                    state_d  = ST_RELEASE;
                    clk_en_d = 1'b1;
                    rel_d    = '0;
                    if (mism_d != '0) begin
                        err_d = 1'b1;
                    end
                end else if (ser_last) begin
                    state_d = ST_FETCH;
                end
            end
            ST_RELEASE: begin
                if (rel_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d = ST_FIN;
                end else begin
                    rel_d = rel_q + RC_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            rem_q    <= '0;
            mism_q   <= '0;
            rel_q    <= '0;
            verify_q <= 1'b0;
            err_q    <= 1'b0;
            clk_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rem_q    <= rem_d;
            mism_q   <= mism_d;
            rel_q    <= rel_d;
            verify_q <= verify_d;
            err_q    <= err_d;
            clk_en_q <= clk_en_d;
        end
    end

    assign cfg_ready     = (state_q == ST_FETCH);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_FIN);
    assign fabric_reset  = (state_q == ST_RELEASE);
    assign fabric_clk_en = clk_en_q;
    assign err           = err_q;
    assign mismatch_cnt  = mism_q;
    assign scan_en       = sel_onehot;
    assign scan_in       = sel_onehot & {NUM_CHAINS{ser_bit}};

endmodule
`default_nettype wire

// File: tb/tb_scan_cfg_loader.sv
`default_nettype none
// ==========================================================================
// tb_scan_cfg_loader : directed bench with an expected-bit scoreboard and a
// 12-bit model of chain 0.  Rev 1.0
// ==========================================================================
module tb_scan_cfg_loader;
    import scan_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  chain_sel = '0;
    logic [15:0] bit_count = '0;
    logic        verify = 1'b0;
    logic [7:0]  cfg_data = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  scan_en, scan_in, scan_out;
    logic        busy, done, err;
    logic [15:0] mismatch_cnt;
    logic        fabric_clk_en, fabric_reset;

    logic [11:0] chain0 = '0;
    bit          exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          shift_cnt = 0;

    scan_cfg_loader #(
        .NUM_CHAINS (2),
        .DATA_W     (8),
        .CNT_W      (16),
        .RST_CYCLES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .chain_sel     (chain_sel),
        .bit_count     (bit_count),
        .verify        (verify),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .scan_en       (scan_en),
        .scan_in       (scan_in),
        .scan_out      (scan_out),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .mismatch_cnt  (mismatch_cnt),
        .fabric_clk_en (fabric_clk_en),
        .fabric_reset  (fabric_reset)
    );

    always #5 clk = ~clk;

    // Chain 0: bits enter at [0] and leave from [11].
    always @(posedge clk) begin
        if (scan_en[0]) chain0 <= {chain0[10:0], scan_in[0]};
    end
    assign scan_out = {1'b0, chain0[11]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        bit e;
        forever begin
            @(negedge clk);
            if (reset && (scan_en != 2'b00)) begin
                shift_cnt++;
                check("scan_en_onehot", {30'd0, scan_en}, 32'd1);
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("scan_in", {30'd0, scan_in}, {31'd0, e});
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {cfg_ready, scan_en, scan_in, busy, done, err, mismatch_cnt,
                    fabric_clk_en, fabric_reset}, 32'd0);
    endtask

    task automatic send_word(input logic [7:0] w, input int stall);
        int t = 0;
        while (!cfg_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
        for (int s = 0; s < stall; s++) begin
            check("stall_scan_en", {30'd0, scan_en}, 32'd0);
            @(negedge clk);
        end
        cfg_data  = w;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                            input logic ver, input int stall,
                            input logic exp_err, input logic [15:0] exp_mm);
        int  base;
        int  rcyc = 0;
        bit  seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) exp_q.push_back(w0[i]);
            else       exp_q.push_back(w1[i-8]);
        end
        base = shift_cnt;
        @(negedge clk);
        start = 1'b1; chain_sel = 2'(CHAIN_CLB); bit_count = 16'd12; verify = ver;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_clk_en_off"}, {31'd0, fabric_clk_en}, 32'd0);
        send_word(w0, 0);
        send_word(w1, stall);
        for (int c = 0; c < 100 && !seen_done; c++) begin
            @(negedge clk);
            if (fabric_reset) begin
                rcyc++;
                check({tag, "_clk_en_in_rst"}, {31'd0, fabric_clk_en}, 32'd1);
            end
            if (done) seen_done = 1'b1;
        end
        check({tag, "_done_seen"}, {31'd0, seen_done}, 32'd1);
        check({tag, "_rst_cycles"}, rcyc, 32'd2);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_mismatch"}, {16'd0, mismatch_cnt}, {16'd0, exp_mm});
        check({tag, "_shifts"}, shift_cnt - base, 32'd12);
        check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
        check({tag, "_err_sticky"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_clk_en_hold"}, {31'd0, fabric_clk_en}, 32'd1);
    endtask

    task automatic run_illegal(input string tag, input logic [1:0] sel, input logic [15:0] cnt);
        int base = shift_cnt;
        @(negedge clk);
        start = 1'b1; chain_sel = sel; bit_count = cnt; verify = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done"}, {30'd0, done, err}, 32'd3);
        check({tag, "_clk_en"}, {31'd0, fabric_clk_en}, 32'd0);
        check({tag, "_no_ready"}, {31'd0, cfg_ready}, 32'd0);
        @(negedge clk);
        check({tag, "_idle"}, {30'd0, done, busy}, 32'd0);
        check({tag, "_err_sticky"}, {31'd0, err}, 32'd1);
        check({tag, "_no_shift"}, shift_cnt - base, 32'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        check_all_zero("reset_outputs");
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset_idle");

        run_load("normal", 8'hB3, 8'h05, 1'b0, 0, 1'b0, 16'd0);
        check("normal_chain", {20'd0, chain0}, 32'hCDA);

        run_load("verify_pass", 8'hB3, 8'h05, 1'b1, 0, 1'b0, 16'd0);
        run_load("verify_fail", 8'h00, 8'h00, 1'b1, 0, 1'b1, 16'd7);

        run_load("stall", 8'hB3, 8'h05, 1'b0, 3, 1'b0, 16'd0);
        check("stall_chain", {20'd0, chain0}, 32'hCDA);

        run_illegal("zero_count", 2'(CHAIN_CLB), 16'd0);
        run_illegal("bad_sel", 2'd2, 16'd12);

        // Reset during the fifth shift of a verify load against 0xCDA.
        @(negedge clk);
        start = 1'b1; chain_sel = 2'(CHAIN_CLB); bit_count = 16'd12; verify = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
        @(negedge clk);
        start = 1'b0;
        send_word(8'h00, 0);
        repeat (5) @(negedge clk);
        check("mid_shift_en", {30'd0, scan_en}, 32'd1);
        check("mid_shift_mm", {16'd0, mismatch_cnt}, 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("after_reset_busy", {31'd0, busy}, 32'd0);

        run_load("after_reset", 8'hB3, 8'h05, 1'b0, 0, 1'b0, 16'd0);
        check("after_reset_chain", {20'd0, chain0}, 32'hCDA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
